// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter, LSB first.
// A word is accepted on a valid/ready handshake, shifted out with each bit
// held for CLKS_PER_BIT cycles while ena_o is high, followed by a single
// done_o pulse. All outputs come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word; ready_o high once out of reset
// S_SHIFT | frame in progress; ena_o high, data_o carries current bit
// S_DONE  | one-cycle done_o pulse after the last bit
module serial_tx #(
   parameter int DATA_WIDTH   = 10,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  data_o,
   output logic                  ena_o,
   output logic                  done_o
);

   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic                  ready_q, ready_d;
   logic                  data_q, data_d;
   logic                  ena_q, ena_d;
   logic                  done_q, done_d;
   logic                  accept;

   // ready_q is low in the first cycle after reset, so gating on it keeps a
   // handshake in that cycle from being taken.
   assign accept = (state_q == S_IDLE) && ready_q && valid_i;

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         pcnt_q  <= '0;
         bcnt_q  <= '0;
         ready_q <= 1'b0;
         data_q  <= 1'b0;
         ena_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         pcnt_q  <= pcnt_d;
         bcnt_q  <= bcnt_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         ena_q   <= ena_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: handshake load, per-bit period counting and bit advance.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      pcnt_d  = pcnt_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shreg_d = data_i;
               pcnt_d  = '0;
               bcnt_d  = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (pcnt_q == P_LAST) begin
               pcnt_d = '0;
               if (bcnt_q == B_LAST) begin
                  state_d = S_DONE;
               end else begin
                  bcnt_d  = bcnt_q + 1'b1;
                  shreg_d = shreg_q >> 1;
               end
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      ready_d = (state_d == S_IDLE);
      ena_d   = (state_d == S_SHIFT);
      done_d  = (state_d == S_DONE);
      data_d  = ena_d & shreg_d[0];
   end

   assign ready_o = ready_q;
   assign data_o  = data_q;
   assign ena_o   = ena_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (CLKS_PER_BIT 1 and 4) share one
// stimulus stream; a frame-timeline reference model predicts every output
// each cycle, and a behavioural receiver on the fast instance loops words back.
module tb_serial_tx;

   localparam int DW = 10;
   localparam int M_IDLE = 0;
   localparam int M_RST  = 1;
   localparam int M_FRM  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [DW-1:0] data;
   logic [1:0]    rdy, dout, ena, done;

   always #5 clk = ~clk;

   serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_tx1 (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
      .ready_o(rdy[0]), .data_o(dout[0]), .ena_o(ena[0]), .done_o(done[0]));

   serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_tx4 (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
      .ready_o(rdy[1]), .data_o(dout[1]), .ena_o(ena[1]), .done_o(done[1]));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int cpb_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   // Reference model: mode plus cycle index t within the current frame.
   // t in 0..DW*cpb-1 is a frame bit, t == DW*cpb is the done cycle.
   int            mode [2];
   int            t    [2];
   logic [DW-1:0] word [2];
   bit            started = 0;
   logic [DW-1:0] txq[$];

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            mode[i] = M_RST;
         end else if (mode[i] == M_RST) begin
            mode[i] = M_IDLE;
         end else if (mode[i] == M_IDLE) begin
            if (valid) begin
               mode[i] = M_FRM;
               t[i]    = 0;
               word[i] = data;
               if (i == 0) txq.push_back(data);
            end
         end else begin
            t[i]++;
            if (t[i] > DW * cpb_of(i)) mode[i] = M_IDLE;
         end
      end
      if (!rst) begin
         started = 1;
         txq.delete();
      end
   end

   // Loopback receiver state for the CLKS_PER_BIT=1 instance.
   logic [DW-1:0] rx_word = '0;
   int            rx_cnt   = 0;
   int            rx_words = 0;

   // Compare outputs against the model away from the active edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            int   c;
            logic e_rdy, e_ena, e_done, e_dat;
            c      = cpb_of(i);
            e_rdy  = (mode[i] == M_IDLE);
            e_ena  = (mode[i] == M_FRM) && (t[i] < DW * c);
            e_done = (mode[i] == M_FRM) && (t[i] == DW * c);
            e_dat  = e_ena ? word[i][t[i] / c] : 1'b0;
            chk($sformatf("d%0d_ready", i), 32'(rdy[i]),  32'(e_rdy));
            chk($sformatf("d%0d_ena",   i), 32'(ena[i]),  32'(e_ena));
            chk($sformatf("d%0d_done",  i), 32'(done[i]), 32'(e_done));
            chk($sformatf("d%0d_data",  i), 32'(dout[i]), 32'(e_dat));
         end
         if (mode[0] == M_RST) begin
            rx_cnt = 0;
         end else begin
            if (ena[0]) begin
               if (rx_cnt < DW) rx_word[rx_cnt] = dout[0];
               rx_cnt++;
            end
            if (done[0]) begin
               chk("rx_len", 32'(rx_cnt), 32'(DW));
               chk("rx_q_nonempty", 32'(txq.size() > 0), 32'd1);
               if (txq.size() > 0) chk("rx_word", 32'(rx_word), 32'(txq.pop_front()));
               rx_cnt = 0;
               rx_words++;
            end
         end
      end
   end

   task automatic put(input logic r, input logic v, input logic [DW-1:0] d);
      rst   = r;
      valid = v;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset, including handshakes that must be refused while in reset.
      repeat (2) put(1'b0, 1'b0, '0);
      repeat (2) put(1'b0, 1'b1, 10'h3FF);
      repeat (3) put(1'b1, 1'b0, '0);

      // Reference frame, data_i noise afterwards with valid low.
      put(1'b1, 1'b1, 10'b1100011011);
      repeat (50) put(1'b1, 1'b0, 10'($urandom));

      put(1'b1, 1'b1, 10'h2A5);
      repeat (50) put(1'b1, 1'b0, '0);

      // valid held high: back-to-back frames.
      put(1'b1, 1'b1, 10'h3FF);
      repeat (50) put(1'b1, 1'b1, 10'h001);
      repeat (50) put(1'b1, 1'b0, '0);

      // Input churn during a frame.
      put(1'b1, 1'b1, 10'h155);
      repeat (45) put(1'b1, 1'($urandom % 2), 10'($urandom));
      repeat (50) put(1'b1, 1'b0, '0);

      // Reset during bit 5 of the fast instance's frame, then a clean word.
      put(1'b1, 1'b1, 10'h2C7);
      repeat (5) put(1'b1, 1'b0, '0);
      put(1'b0, 1'b0, '0);
      put(1'b1, 1'b0, '0);
      put(1'b1, 1'b1, 10'h0F0);
      repeat (50) put(1'b1, 1'b0, '0);

      // Random traffic with rare resets.
      repeat (2500) put(1'(($urandom % 400) != 0), 1'(($urandom % 3) != 0), 10'($urandom));
      repeat (60) put(1'b1, 1'b0, '0);

      chk("rx_words_ge_100", 32'(rx_words >= 100), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
